// File: rtl/regfile_param_sb.sv
// -----------------------------------------------------------------------------
// regfile_param_sb
//   Parametrised register file with NUM_RD combinational read ports, an
//   optional hardwired zero register (ZERO_REG) and a per-register busy
//   scoreboard. Decode locks destinations (busy <= 1); writeback writes data
//   and clears busy. A lock and a write to the same register on the same edge
//   leave it busy, because the lock belongs to a newer producer.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a read that hits the register being written this cycle
//                 returns wrData, and its busy flag drops unless it is being
//                 re-locked on the same cycle.
//     undefined : reads always return the stored value; write-to-read
//                 latency is one cycle.
// -----------------------------------------------------------------------------
module regfile_param_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     lock,
  input  logic [ADDR_W-1:0]        lockAddr,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdBusy,
  output logic                     anyBusy,
  output logic [ADDR_W:0]          busyCnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  // A ZERO_REG outside the address range means there is no zero register.
  localparam bit HAS_ZERO = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // True when the address names the hardwired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return HAS_ZERO && (addr == ZERO_ADDR);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;
  logic              any_busy_q;
  logic              any_busy_d;

  logic              write_ok_s;
  logic              lock_ok_s;
  logic [ADDR_W-1:0] rd_addr_s;

  assign write_ok_s = write && !is_zero(wrAddr);
  assign lock_ok_s  = lock  && !is_zero(lockAddr);

  // Next-state of storage and scoreboard: write clears busy, lock sets it and wins.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k]  = (write_ok_s && (wrAddr == ADDR_W'(k))) ? wrData : mem_q[k];
      busy_d[k] = (lock_ok_s && (lockAddr == ADDR_W'(k))) ? 1'b1 :
                  (write_ok_s && (wrAddr == ADDR_W'(k))) ? 1'b0 : busy_q[k];
    end
  end

  // Population count of the next busy vector so busyCnt moves with the busy bits.
  always_comb begin
    busy_cnt_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[k]);
    end
    any_busy_d = |busy_d;
  end

  // State registers; asynchronous reset discards any lock/write of that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
      any_busy_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      any_busy_q <= any_busy_d;
    end
  end

  // Zero-latency read ports with zero-register masking and optional write bypass.
  always_comb begin
    rdData    = '0;
    rdBusy    = '0;
    rd_addr_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr_s = rdAddr[i*ADDR_W +: ADDR_W];
      if (is_zero(rd_addr_s)) begin
        rdData[i*DATA_W +: DATA_W] = '0;
        rdBusy[i]                  = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (write_ok_s && (wrAddr == rd_addr_s)) begin
        rdData[i*DATA_W +: DATA_W] = wrData;
        rdBusy[i]                  = lock && (lockAddr == rd_addr_s);
      end
`endif
      else begin
        rdData[i*DATA_W +: DATA_W] = mem_q[rd_addr_s];
        rdBusy[i]                  = busy_q[rd_addr_s];
      end
    end
  end

  assign anyBusy = any_busy_q;
  assign busyCnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_param_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_param_sb
//   Directed scenarios followed by a randomized phase. Expected values come
//   from a plain array model of the register file and busy set.
// -----------------------------------------------------------------------------
module tb_regfile_param_sb;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 3;
  localparam int ZERO_REG = 31;
  localparam int DEPTH    = 32;

  logic                     clk      = 1'b0;
  logic                     clk_en   = 1'b0;
  logic                     reset    = 1'b0;
  logic                     write    = 1'b0;
  logic [ADDR_W-1:0]        wrAddr   = '0;
  logic [DATA_W-1:0]        wrData   = '0;
  logic                     lock     = 1'b0;
  logic [ADDR_W-1:0]        lockAddr = '0;
  logic [NUM_RD*ADDR_W-1:0] rdAddr   = '0;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     anyBusy;
  logic [ADDR_W:0]          busyCnt;

  int passed = 0;
  int total  = 0;

  // Reference model
  logic [DATA_W-1:0] m_mem  [DEPTH];
  bit                m_busy [DEPTH];

  regfile_param_sb #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
    .lock(lock), .lockAddr(lockAddr), .rdAddr(rdAddr), .rdData(rdData),
    .rdBusy(rdBusy), .anyBusy(anyBusy), .busyCnt(busyCnt)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_rd(input int p, input logic [ADDR_W-1:0] a);
    rdAddr[p*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int p);
    return rdData[p*DATA_W +: DATA_W];
  endfunction

  function automatic logic [ADDR_W-1:0] port_addr(input int p);
    return rdAddr[p*ADDR_W +: ADDR_W];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int k = 0; k < DEPTH; k++) n += int'(m_busy[k]);
    return n;
  endfunction

  function automatic logic [DATA_W-1:0] model_data(input int a);
    if (a == ZERO_REG) return '0;
`ifdef REGFILE_BYPASS_EN
    if (write && int'(wrAddr) == a) return wrData;
`endif
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input int a);
    if (a == ZERO_REG) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (write && int'(wrAddr) == a) return lock && int'(lockAddr) == a;
`endif
    return m_busy[a];
  endfunction

  // Advance one clock edge and apply the inputs present at that edge to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (write && int'(wrAddr) != ZERO_REG) begin
        m_mem[wrAddr]  = wrData;
        m_busy[wrAddr] = 1'b0;
      end
      if (lock && int'(lockAddr) != ZERO_REG) m_busy[lockAddr] = 1'b1;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      chk({tag, "_data"}, port_data(p), model_data(int'(port_addr(p))));
      chk({tag, "_busy"}, DATA_W'(rdBusy[p]), DATA_W'(model_busy(int'(port_addr(p)))));
    end
    chk({tag, "_cnt"}, DATA_W'(busyCnt), DATA_W'(model_count()));
    chk({tag, "_any"}, DATA_W'(anyBusy), DATA_W'(model_count() != 0));
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int sel = int'($urandom_range(0, 3));
    if (sel == 0) return ADDR_W'(ZERO_REG);
    if (sel == 3) return ADDR_W'($urandom_range(0, DEPTH-1));
    return ADDR_W'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [DATA_W-1:0] exp_d;

    // 1. Reset with no clock running
    #1 reset = 1'b1;
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      for (int p = 0; p < NUM_RD; p++) set_rd(p, ADDR_W'(a));
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        chk("rst_data", port_data(p), '0);
        chk("rst_busy", DATA_W'(rdBusy[p]), '0);
      end
    end
    chk("rst_cnt", DATA_W'(busyCnt), '0);
    chk("rst_any", DATA_W'(anyBusy), '0);

    clk_en = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;

    // 2. Write r5, read it on two ports next cycle
    write = 1'b1; wrAddr = 5'd5; wrData = 64'hDEAD_BEEF_0000_0001;
    tick();
    write = 1'b0;
    set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd0);
    #1;
    chk("r5_p0", port_data(0), 64'hDEAD_BEEF_0000_0001);
    chk("r5_p1", port_data(1), 64'hDEAD_BEEF_0000_0001);
    check_model("t2");

    // 3. Zero register ignores writes and locks
    write = 1'b1; wrAddr = 5'd31; wrData = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    write = 1'b0;
    set_rd(0, 5'd31);
    #1;
    chk("r31_data", port_data(0), '0);
    lock = 1'b1; lockAddr = 5'd31;
    tick();
    lock = 1'b0;
    #1;
    chk("r31_busy", DATA_W'(rdBusy[0]), '0);
    chk("r31_cnt", DATA_W'(busyCnt), '0);

    // 4. Lock r7, then write+lock r7, then write r7 alone
    lock = 1'b1; lockAddr = 5'd7;
    tick();
    lock = 1'b0;
    set_rd(0, 5'd7);
    #1;
    chk("r7_lock_busy", DATA_W'(rdBusy[0]), 64'd1);
    chk("r7_lock_cnt", DATA_W'(busyCnt), 64'd1);
    write = 1'b1; wrAddr = 5'd7; wrData = 64'h42; lock = 1'b1; lockAddr = 5'd7;
    tick();
    write = 1'b0; lock = 1'b0;
    #1;
    chk("r7_both_busy", DATA_W'(rdBusy[0]), 64'd1);
    chk("r7_both_data", port_data(0), 64'h42);
    chk("r7_both_cnt", DATA_W'(busyCnt), 64'd1);
    write = 1'b1; wrAddr = 5'd7; wrData = 64'h43;
    tick();
    write = 1'b0;
    #1;
    chk("r7_wr_busy", DATA_W'(rdBusy[0]), '0);
    chk("r7_wr_cnt", DATA_W'(busyCnt), '0);
    check_model("t4");

    // 5. Same-cycle write and read of a locked r3
    lock = 1'b1; lockAddr = 5'd3;
    tick();
    lock = 1'b0;
    write = 1'b1; wrAddr = 5'd3; wrData = 64'h1234;
    set_rd(0, 5'd3);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", port_data(0), 64'h1234);
    chk("byp_busy", DATA_W'(rdBusy[0]), '0);
`else
    chk("nobyp_data", port_data(0), '0);
    chk("nobyp_busy", DATA_W'(rdBusy[0]), 64'd1);
`endif
    check_model("t5a");
    tick();
    write = 1'b0;
    #1;
    chk("r3_after_data", port_data(0), 64'h1234);
    chk("r3_after_busy", DATA_W'(rdBusy[0]), '0);

    // 6. Lock r1..r3, then asynchronous reset mid-cycle
    write = 1'b1; wrAddr = 5'd1; wrData = 64'h11;
    tick();
    write = 1'b1; wrAddr = 5'd2; wrData = 64'h22; lock = 1'b1; lockAddr = 5'd1;
    tick();
    write = 1'b0; lockAddr = 5'd2;
    tick();
    lockAddr = 5'd3;
    tick();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3);
    #1;
    chk("pre_rst_cnt", DATA_W'(busyCnt), 64'd3);
    check_model("t6pre");
    write = 1'b1; wrAddr = 5'd4; wrData = 64'h99;
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_any", DATA_W'(anyBusy), '0);
    chk("mid_rst_cnt", DATA_W'(busyCnt), '0);
    for (int p = 0; p < NUM_RD; p++) chk("mid_rst_data", port_data(p), '0);
    tick();
    #1 reset = 1'b0;
    write = 1'b0; lock = 1'b0;
    set_rd(0, 5'd4);
    check_model("t6post");

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      write    = 1'($urandom_range(0, 1));
      wrAddr   = rand_addr();
      exp_d    = {$urandom, $urandom};
      wrData   = exp_d;
      lock     = 1'($urandom_range(0, 1));
      lockAddr = ($urandom_range(0, 3) == 0) ? wrAddr : rand_addr();
      for (int p = 0; p < NUM_RD; p++) begin
        set_rd(p, ($urandom_range(0, 2) == 0) ? wrAddr : rand_addr());
      end
      check_model("rnd");
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        model_clear();
        check_model("rnd_rst");
        reset = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
